// File: rtl/i2c_slave_regs.sv
// I2C target with a 16x8 register file, auto-incrementing pointer, no clock stretching.
// Optional: define I2C_SLAVE_GLITCH_FILTER_EN for a 3-sample majority filter on SCL/SDA.
`timescale 1ns/1ps
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h48,
    parameter int         REG_DEPTH_LOG2 = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      SCL_i,
    input  logic                      SDA_i,
    output logic                      SDA_o,
    output logic                      SDA_t,
    input  logic [REG_DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]                rd_data,
    output logic                      wr_strobe,
    output logic [REG_DEPTH_LOG2-1:0] wr_addr,
    output logic                      busy
);

    localparam int DEPTH = 1 << REG_DEPTH_LOG2;

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, RACK
    } state_t;

    state_t                    r_state;
    logic [7:0]                r_regs [DEPTH];
    logic [REG_DEPTH_LOG2-1:0] r_ptr;
    logic [7:0]                r_shift;
    logic [2:0]                r_cnt;
    logic                      r_done;
    logic                      r_mack;

    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic r_scl_d, r_sda_d;
    logic w_scl, w_sda;
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_rx_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= SCL_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= SDA_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] r_scl_h, r_sda_h;
    logic       r_scl_m, r_sda_m;

    // Majority of three consecutive samples drops any single-cycle pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_h <= 2'b11;
            r_sda_h <= 2'b11;
            r_scl_m <= 1'b1;
            r_sda_m <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[0], r_scl_s2};
            r_sda_h <= {r_sda_h[0], r_sda_s2};
            r_scl_m <= (r_scl_s2 & r_scl_h[0]) | (r_scl_s2 & r_scl_h[1])
                     | (r_scl_h[0] & r_scl_h[1]);
            r_sda_m <= (r_sda_s2 & r_sda_h[0]) | (r_sda_s2 & r_sda_h[1])
                     | (r_sda_h[0] & r_sda_h[1]);
        end
    end

    assign w_scl = r_scl_m;
    assign w_sda = r_sda_m;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_rx_state = (r_state == ADDR) | (r_state == PTR)
                      | (r_state == WDATA);

    assign SDA_o   = 1'b0;
    assign rd_data = r_regs[rd_addr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            SDA_t     <= 1'b1;
            r_ptr     <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_mack    <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (w_stop) begin
                r_state <= IDLE;
                SDA_t   <= 1'b1;
                busy    <= 1'b0;
            end else if (w_start) begin
                r_state <= ADDR;
                SDA_t   <= 1'b1;
                r_cnt   <= '0;
                r_done  <= 1'b0;
            end else begin
                if (w_scl_rise && w_rx_state) begin
                    r_shift <= {r_shift[6:0], w_sda};
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_done <= 1'b1;
                end
                if (w_scl_rise && r_state == RACK) r_mack <= w_sda;
                // Byte actions happen on the SCL fall that ends a bit
                if (w_scl_fall) begin
                    unique case (r_state)
                        ADDR: if (r_done) begin
                            r_done <= 1'b0;
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                r_state <= ACK_ADDR;
                                SDA_t   <= 1'b0;
                                busy    <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                SDA_t   <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end
                        ACK_ADDR: begin
                            r_cnt <= '0;
                            if (r_shift[0]) begin
                                r_state <= RDATA;
                                r_shift <= r_regs[r_ptr];
                                SDA_t   <= r_regs[r_ptr][7];
                            end else begin
                                r_state <= PTR;
                                SDA_t   <= 1'b1;
                            end
                        end
                        PTR: if (r_done) begin
                            r_done  <= 1'b0;
                            r_ptr   <= r_shift[REG_DEPTH_LOG2-1:0];
                            r_state <= ACK_PTR;
                            SDA_t   <= 1'b0;
                        end
                        ACK_PTR: begin
                            r_state <= WDATA;
                            SDA_t   <= 1'b1;
                        end
                        WDATA: if (r_done) begin
                            r_done         <= 1'b0;
                            r_regs[r_ptr]  <= r_shift;
                            wr_strobe      <= 1'b1;
                            wr_addr        <= r_ptr;
                            r_ptr          <= r_ptr + 1'b1;
                            r_state        <= ACK_W;
                            SDA_t          <= 1'b0;
                        end
                        ACK_W: begin
                            r_state <= WDATA;
                            SDA_t   <= 1'b1;
                        end
                        RDATA: begin
                            if (r_cnt == 3'd7) begin
                                r_ptr   <= r_ptr + 1'b1;
                                r_state <= RACK;
                                SDA_t   <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                SDA_t   <= r_shift[6];
                                r_cnt   <= r_cnt + 3'd1;
                            end
                        end
                        RACK: begin
                            if (!r_mack) begin
                                r_state <= RDATA;
                                r_shift <= r_regs[r_ptr];
                                SDA_t   <= r_regs[r_ptr][7];
                                r_cnt   <= '0;
                            end else begin
                                r_state <= IDLE;
                                SDA_t   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h48, the 7-bit I2C target address.
REQ-002 The block SHALL have parameter REG_DEPTH_LOG2, default 4, the log2 of the register-file depth (16 x 8-bit registers).
REQ-003 The block SHALL have port clock, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port SCL_i, input, 1 bit: raw SCL pin level.
REQ-006 The block SHALL have port SDA_i, input, 1 bit: raw SDA pin level.
REQ-007 The block SHALL have port SDA_o, output, 1 bit: SDA drive value, constant 0 (open-drain).
REQ-008 The block SHALL have port SDA_t, output, 1 bit: SDA tristate control, 1 = released, 0 = drive SDA_o.
REQ-009 The block SHALL have port rd_addr, input, REG_DEPTH_LOG2 bits: local read address.
REQ-010 The block SHALL have port rd_data, output, 8 bits: combinational register-file read of rd_addr.
REQ-011 The block SHALL have port wr_strobe, output, 1 bit: one-cycle pulse when a register is written over I2C.
REQ-012 The block SHALL have port wr_addr, output, REG_DEPTH_LOG2 bits: address of the last I2C write, valid with wr_strobe.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 from an addressed START until STOP or address mismatch.

Function
REQ-014 SCL_i and SDA_i SHALL each pass through a 2-flop synchronizer; all edge and condition detection SHALL use the synchronized signals.
REQ-015 START SHALL be detected as a synchronized SDA falling edge while SCL is high; STOP as an SDA rising edge while SCL is high.
REQ-016 Data bits SHALL be sampled MSB first on the SCL rising edge; SDA_t SHALL change only in the clock cycle after a detected SCL falling edge.
REQ-017 The FSM states SHALL be IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, RACK.
REQ-018 IDLE SHALL leave on START to ADDR.
REQ-019 ADDR SHALL shift in 8 bits; on a match of SLAVE_ADDR it SHALL go to ACK_ADDR, otherwise to IDLE with SDA released.
REQ-020 ACK_ADDR SHALL hold SDA low for exactly one SCL period, then go to RDATA if R/W=1, else to PTR.
REQ-021 PTR SHALL load the low REG_DEPTH_LOG2 bits of the received byte into the pointer and go to ACK_PTR, which SHALL acknowledge and then enter WDATA.
REQ-022 WDATA SHALL, after 8 bits, write reg[ptr], pulse wr_strobe for one cycle with wr_addr=ptr, increment ptr, and acknowledge in ACK_W before returning to WDATA.
REQ-023 RDATA SHALL drive reg[ptr] MSB first (SDA_t=0 for a 0 bit, 1 for a 1 bit), increment ptr after bit 0, and go to RACK.
REQ-024 RACK SHALL release SDA and sample the master's ACK; on ACK (0) it SHALL go to RDATA, on NACK (1) to IDLE.
REQ-025 The pointer SHALL wrap from REG_DEPTH-1 to 0 on increment; the pointer SHALL persist across transactions.
REQ-026 A repeated START in any state SHALL release SDA and go to ADDR without writing a partially received byte.
REQ-027 STOP in any state SHALL release SDA, go to IDLE and clear busy in the next cycle.
REQ-028 If START and STOP are detected in the same cycle, STOP SHALL take priority.
REQ-029 Clock stretching SHALL NOT be performed; SCL SHALL never be driven.

Reset
REQ-030 reset_n low SHALL asynchronously set state=IDLE, SDA_t=1, ptr=0, wr_strobe=0, wr_addr=0, busy=0, all registers=8'h00 and synchronizers=1.
REQ-031 Reset asserted mid-transfer SHALL release SDA within the same cycle, and the block SHALL ignore the bus until the next START.

Configuration
REQ-032 With I2C_SLAVE_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow each synchronizer (+2 cycles latency) and suppress pulses of 1 clock or less.
REQ-033 Without I2C_SLAVE_GLITCH_FILTER_EN, the synchronizer outputs SHALL be used directly.

Verification
REQ-034 START, 0x90, 0x03, 0xA5, STOP -> ACK on all 3 bytes, reg[3]=0xA5, one wr_strobe with wr_addr=3, busy=0 after STOP.
REQ-035 START, 0x90, 0x0F, 0x11, 0x22, STOP -> reg[15]=0x11, reg[0]=0x22 (pointer wrap), 2 wr_strobe pulses.
REQ-036 START, 0x90, 0x03, Sr, 0x91, master ACK, master NACK, STOP -> reads 0xA5 then reg[4]; SDA released after NACK.
REQ-037 START, 0xA0, 0x55 -> no ACK (SDA_t=1 throughout), busy=0, registers unchanged.
REQ-038 Drive reset_n low during bit 4 of a read byte -> SDA_t=1 immediately; next START, 0x91 returns reg[0]=0x00.
REQ-039 With I2C_SLAVE_GLITCH_FILTER_EN defined, a 1-cycle SCL low glitch mid-byte -> no extra bit shifted and the byte is received correctly.
